// File: rtl/matmul_pkg.sv
// Shared types and constants for the systolic matmul sequencer and its APB register map.
package matmul_pkg;
    localparam int MM_AWIDTH       = 10;
    localparam int MM_STRIDE_WIDTH = 8;

    localparam int REG_START     = 1;
    localparam int REG_DONE      = 2;
    localparam int REG_EXCEPTION = 3;
    localparam int REG_ADDR_A    = 4;
    localparam int REG_ADDR_B    = 5;
    localparam int REG_ADDR_C    = 6;
    localparam int REG_STRIDE_A  = 7;
    localparam int REG_STRIDE_B  = 8;
    localparam int REG_STRIDE_C  = 9;

    localparam int NUM_CH = 3;
    localparam int CH_A   = 0;
    localparam int CH_B   = 1;
    localparam int CH_C   = 2;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_DRAIN, S_WRITE, S_FIN
    } state_t;
endpackage

// File: rtl/matmul_addr_gen.sv
// Loadable base/stride address walker; also flags when the last of N addresses would overflow.
module matmul_addr_gen
    import matmul_pkg::*;
#(
    parameter int N      = 4,
    parameter int AWIDTH = MM_AWIDTH,
    parameter int SW     = MM_STRIDE_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [AWIDTH-1:0] base,
    input  logic [SW-1:0]     stride,
    output logic [AWIDTH-1:0] addr,
    output logic              ovf
);
    localparam int W = AWIDTH + SW + 1;

    logic [SW-1:0] stride_q;
    logic [W-1:0]  last_addr;

    // Valid only while addr still holds the base, i.e. before the first step.
    assign last_addr = W'(addr) + W'(N - 1) * W'(stride_q);
    assign ovf       = last_addr > W'({AWIDTH{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            stride_q <= '0;
        end else if (load) begin
            addr     <= base;
            stride_q <= stride;
        end else if (step) begin
            addr <= addr + AWIDTH'(stride_q);
        end
    end
endmodule

// File: rtl/matmul_sequencer.sv
// Run sequencer for one systolic matmul: clear PEs, stream A/B reads, drain, write C back.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int N                 = 4,
    parameter int AWIDTH            = MM_AWIDTH,
    parameter int ADDR_STRIDE_WIDTH = MM_STRIDE_WIDTH,
    parameter int DRAIN_CYCLES      = 2 * N
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         start,
    input  logic [AWIDTH-1:0]            address_mat_a,
    input  logic [AWIDTH-1:0]            address_mat_b,
    input  logic [AWIDTH-1:0]            address_mat_c,
    input  logic [ADDR_STRIDE_WIDTH-1:0] address_stride_a,
    input  logic [ADDR_STRIDE_WIDTH-1:0] address_stride_b,
    input  logic [ADDR_STRIDE_WIDTH-1:0] address_stride_c,
    output logic [AWIDTH-1:0]            a_addr,
    output logic                         a_en,
    output logic [AWIDTH-1:0]            b_addr,
    output logic                         b_en,
    output logic [AWIDTH-1:0]            c_addr,
    output logic                         c_we,
    output logic                         pe_reset,
    output logic                         busy,
    output logic                         done,
    output logic                         exceptions
);
    localparam int SW      = ADDR_STRIDE_WIDTH;
    localparam int CNT_MAX = (N > DRAIN_CYCLES) ? N : DRAIN_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t                          state;
    logic                            start_q;
    logic                            err_q;
    logic [CW-1:0]                   cnt;
    logic                            start_edge;
    logic                            load;
    logic [NUM_CH-1:0][AWIDTH-1:0]   base;
    logic [NUM_CH-1:0][SW-1:0]       stride;
    logic [NUM_CH-1:0][AWIDTH-1:0]   gen_addr;
    logic [NUM_CH-1:0]               step;
    logic [NUM_CH-1:0]               ovf;

    assign start_edge = start & ~start_q;
    assign load       = (state == S_IDLE) && start_edge;
    assign base       = {address_mat_c, address_mat_b, address_mat_a};
    assign stride     = {address_stride_c, address_stride_b, address_stride_a};
    assign step[CH_A] = (state == S_LOAD);
    assign step[CH_B] = (state == S_LOAD);
    assign step[CH_C] = (state == S_WRITE);

    // The generators hold the latched config, so mid-run input changes are ignored.
    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            matmul_addr_gen #(.N(N), .AWIDTH(AWIDTH), .SW(SW)) u_gen (
                .clk   (PCLK),
                .rst_n (PRESETn),
                .load  (load),
                .step  (step[g]),
                .base  (base[g]),
                .stride(stride[g]),
                .addr  (gen_addr[g]),
                .ovf   (ovf[g])
            );
        end
    endgenerate

    // Outputs are registered decodes of the current state, so they trail it by one cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= S_IDLE;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt        <= '0;
            a_addr     <= '0;
            a_en       <= 1'b0;
            b_addr     <= '0;
            b_en       <= 1'b0;
            c_addr     <= '0;
            c_we       <= 1'b0;
            pe_reset   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            exceptions <= 1'b0;
        end else begin
            start_q  <= start;
            pe_reset <= 1'b0;
            a_en     <= 1'b0;
            b_en     <= 1'b0;
            c_we     <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (start_edge) state <= S_CLEAR;
                end
                S_CLEAR: begin
                    pe_reset   <= 1'b1;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                    exceptions <= 1'b0;
                    err_q      <= |ovf;
                    cnt        <= '0;
                    state      <= (|ovf) ? S_FIN : S_LOAD;
                end
                S_LOAD: begin
                    a_en   <= 1'b1;
                    b_en   <= 1'b1;
                    a_addr <= gen_addr[CH_A];
                    b_addr <= gen_addr[CH_B];
                    if (cnt == CW'(N - 1)) begin
                        cnt   <= '0;
                        state <= S_DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (cnt == CW'(DRAIN_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= S_WRITE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    c_we   <= 1'b1;
                    c_addr <= gen_addr[CH_C];
                    if (cnt == CW'(N - 1)) begin
                        cnt   <= '0;
                        state <= S_FIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    exceptions <= err_q;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: cycle-exact checks of every run phase at default sizes.
module tb_matmul_sequencer;
    localparam int AW = 10;
    localparam int SW = 8;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] address_mat_a = '0, address_mat_b = '0, address_mat_c = '0;
    logic [SW-1:0] address_stride_a = '0, address_stride_b = '0, address_stride_c = '0;
    logic [AW-1:0] a_addr, b_addr, c_addr;
    logic          a_en, b_en, c_we, pe_reset, busy, done, exceptions;

    int checks = 0;
    int errors = 0;

    matmul_sequencer dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .start(start),
        .address_mat_a(address_mat_a), .address_mat_b(address_mat_b),
        .address_mat_c(address_mat_c),
        .address_stride_a(address_stride_a), .address_stride_b(address_stride_b),
        .address_stride_c(address_stride_c),
        .a_addr(a_addr), .a_en(a_en), .b_addr(b_addr), .b_en(b_en),
        .c_addr(c_addr), .c_we(c_we), .pe_reset(pe_reset),
        .busy(busy), .done(done), .exceptions(exceptions)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic cfg(input int a, input int b, input int c, input int sa, input int sb, input int sc);
        address_mat_a    = AW'(a);
        address_mat_b    = AW'(b);
        address_mat_c    = AW'(c);
        address_stride_a = SW'(sa);
        address_stride_b = SW'(sb);
        address_stride_c = SW'(sc);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_en"}, 32'(a_en), 0);
        chk({tag, "_b_en"}, 32'(b_en), 0);
        chk({tag, "_c_we"}, 32'(c_we), 0);
        chk({tag, "_c_addr"}, 32'(c_addr), 0);
        chk({tag, "_a_addr"}, 32'(a_addr), 0);
        chk({tag, "_pe_reset"}, 32'(pe_reset), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_exc"}, 32'(exceptions), 0);
    endtask

    // Full run from a rising start: k counts edges after the sampling edge E.
    // abort_k>0 applies reset after edge E+abort_k; poke injects a second start edge in DRAIN
    // and scrambles the config inputs to prove they are latched.
    task automatic run_full(input int abort_k, input bit poke);
        int xa, xb, xc, xsa, xsb, xsc;
        logic [AW-1:0] ea;
        xa = int'(address_mat_a); xb = int'(address_mat_b); xc = int'(address_mat_c);
        xsa = int'(address_stride_a); xsb = int'(address_stride_b); xsc = int'(address_stride_c);
        start = 1'b1;
        step();
        chk("e0_pe_reset", 32'(pe_reset), 0);
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k == 1) begin
                chk("e1_pe_reset", 32'(pe_reset), 1);
                chk("e1_busy", 32'(busy), 1);
                chk("e1_done", 32'(done), 0);
                chk("e1_exc", 32'(exceptions), 0);
                chk("e1_a_en", 32'(a_en), 0);
            end else if (k <= 5) begin
                chk("load_a_en", 32'(a_en), 1);
                chk("load_b_en", 32'(b_en), 1);
                chk("load_pe_reset", 32'(pe_reset), 0);
                ea = AW'(xa + (k - 2) * xsa);
                chk("load_a_addr", 32'(a_addr), 32'(ea));
                ea = AW'(xb + (k - 2) * xsb);
                chk("load_b_addr", 32'(b_addr), 32'(ea));
            end else if (k <= 13) begin
                chk("drain_a_en", 32'(a_en), 0);
                chk("drain_c_we", 32'(c_we), 0);
                chk("drain_busy", 32'(busy), 1);
            end else if (k <= 17) begin
                chk("write_c_we", 32'(c_we), 1);
                ea = AW'(xc + (k - 14) * xsc);
                chk("write_c_addr", 32'(c_addr), 32'(ea));
                chk("write_done", 32'(done), 0);
            end else begin
                chk("fin_done", 32'(done), 1);
                chk("fin_busy", 32'(busy), 0);
                chk("fin_exc", 32'(exceptions), 0);
                chk("fin_c_we", 32'(c_we), 0);
            end
            if (poke && k == 3) cfg(1000, 900, 1010, 255, 255, 255);
            if (poke && k == 8) start = 1'b0;
            if (poke && k == 9) start = 1'b1;
            if (k == abort_k) begin
                PRESETn = 1'b0;
                start   = 1'b0;
                #1;
                chk_all_zero("rst_mid");
                for (int i = 0; i < 3; i++) begin
                    step();
                    chk("rst_hold_c_we", 32'(c_we), 0);
                end
                PRESETn = 1'b1;
                step();
                chk("rst_rel_busy", 32'(busy), 0);
                chk("rst_rel_done", 32'(done), 0);
                return;
            end
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk_all_zero("reset");
        PRESETn = 1'b1;
        step();
        chk("post_reset_busy", 32'(busy), 0);

        // Unit strides
        cfg(4, 8, 12, 1, 1, 1);
        run_full(0, 1'b0);
        start = 1'b0;
        step();

        // Mixed strides from base 0
        cfg(0, 0, 0, 2, 4, 3);
        run_full(0, 1'b0);
        start = 1'b0;
        step();

        // A overflow: 1020 + 3*2 = 1026 > 1023
        cfg(1020, 0, 0, 2, 1, 1);
        start = 1'b1;
        step();
        step();
        chk("ovf_pe_reset", 32'(pe_reset), 1);
        chk("ovf_busy", 32'(busy), 1);
        chk("ovf_a_en", 32'(a_en), 0);
        step();
        chk("ovf_done", 32'(done), 1);
        chk("ovf_exc", 32'(exceptions), 1);
        chk("ovf_busy_end", 32'(busy), 0);
        chk("ovf_pe_reset_end", 32'(pe_reset), 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("ovf_no_access", 32'({a_en, b_en, c_we}), 0);
            chk("ovf_done_hold", 32'(done), 1);
        end
        start = 1'b0;
        step();

        // Last address exactly 1023 is legal; exceptions from the prior run clear at E+1
        cfg(1017, 5, 7, 2, 1, 1);
        run_full(0, 1'b0);
        start = 1'b0;
        step();

        // Second start edge in DRAIN is ignored; start held high does not relaunch
        cfg(4, 8, 12, 1, 1, 1);
        run_full(0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("held_done", 32'(done), 1);
            chk("held_busy", 32'(busy), 0);
            chk("held_pe_reset", 32'(pe_reset), 0);
        end
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        chk("relaunch_e0_done", 32'(done), 1);
        step();
        chk("relaunch_e1_done", 32'(done), 0);
        chk("relaunch_e1_busy", 32'(busy), 1);
        chk("relaunch_e1_pe_reset", 32'(pe_reset), 1);
        for (int i = 2; i <= 18; i++) step();
        chk("relaunch_fin_done", 32'(done), 1);
        start = 1'b0;
        step();

        // Reset during WRITE after two writes, then a clean run
        cfg(4, 8, 12, 1, 1, 1);
        run_full(15, 1'b0);
        cfg(100, 200, 300, 1, 1, 1);
        run_full(0, 1'b0);
        start = 1'b0;
        step();

        // Stride 0 on C repeats the base
        cfg(16, 32, 500, 1, 2, 0);
        run_full(0, 1'b0);
        start = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
